// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter among NUM_REQ 32-bit producers.
// Define UART_ARB_CHECKSUM_EN to append an XOR checksum byte to every frame.
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter logic [7:0]  HEADER  = 8'hA0
) (
   input  logic                  Clk,
   input  logic                  Rst_n,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [32*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]    req_ack,
   output logic [NUM_REQ-1:0]    gnt,
   output logic                  busy,
   input  logic                  TX_Done,
   output logic                  Send_en,
   output logic [7:0]            data
);

   localparam int unsigned IW = $clog2(NUM_REQ);
`ifdef UART_ARB_CHECKSUM_EN
   localparam logic [2:0] LAST_IDX = 3'd5;
`else
   localparam logic [2:0] LAST_IDX = 3'd4;
`endif

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ARB  = 3'd1,
      SEND = 3'd2,
      WAIT = 3'd3,
      ACK  = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [IW-1:0]        ptr_q, ptr_d;
   logic [IW-1:0]        win_q, win_d;
   logic [31:0]          word_q, word_d;
   logic [2:0]           idx_q, idx_d;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic [NUM_REQ-1:0]   ack_q, ack_d;
   logic                 busy_q, busy_d;
   logic                 send_q, send_d;
   logic [7:0]           data_q, data_d;

   logic                 found;
   logic [IW-1:0]        pick;
   logic [IW-1:0]        cand;
   logic [7:0]           hdr;
   logic [7:0]           cur_byte;

   // First asserted request at or after the round-robin pointer
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int k = 0; k < int'(NUM_REQ); k++) begin
         cand = IW'((int'(ptr_q) + k) % int'(NUM_REQ));
         if (!found && req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   assign hdr = HEADER | 8'(win_q);

   always_comb begin
      cur_byte = 8'd0;
      case (idx_q)
         3'd0: cur_byte = hdr;
         3'd1: cur_byte = word_q[31:24];
         3'd2: cur_byte = word_q[23:16];
         3'd3: cur_byte = word_q[15:8];
         3'd4: cur_byte = word_q[7:0];
`ifdef UART_ARB_CHECKSUM_EN
         3'd5: cur_byte = hdr ^ word_q[31:24] ^ word_q[23:16] ^ word_q[15:8] ^ word_q[7:0];
`endif
         default: cur_byte = 8'd0;
      endcase
   end

   // Next state and next registered outputs
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      word_d  = word_q;
      idx_d   = idx_q;
      gnt_d   = gnt_q;
      busy_d  = busy_q;
      data_d  = data_q;
      ack_d   = '0;
      send_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (|req) state_d = ARB;
         end
         ARB: begin
            if (found) begin
               win_d       = pick;
               word_d      = req_data[32*pick +: 32];
               gnt_d       = '0;
               gnt_d[pick] = 1'b1;
               busy_d      = 1'b1;
               idx_d       = 3'd0;
               state_d     = SEND;
            end else begin
               state_d = IDLE;
            end
         end
         SEND: begin
            data_d  = cur_byte;
            send_d  = 1'b1;
            state_d = WAIT;
         end
         WAIT: begin
            if (TX_Done) begin
               if (idx_q == LAST_IDX) begin
                  ack_d        = '0;
                  ack_d[win_q] = 1'b1;
                  gnt_d        = '0;
                  busy_d       = 1'b0;
                  data_d       = 8'd0;
                  ptr_d        = (win_q == IW'(NUM_REQ - 1)) ? '0 : win_q + IW'(1);
                  state_d      = ACK;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  state_d = SEND;
               end
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            gnt_d   = '0;
            busy_d  = 1'b0;
            data_d  = 8'd0;
            idx_d   = 3'd0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         win_q   <= '0;
         word_q  <= '0;
         idx_q   <= 3'd0;
         gnt_q   <= '0;
         ack_q   <= '0;
         busy_q  <= 1'b0;
         send_q  <= 1'b0;
         data_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         word_q  <= word_d;
         idx_q   <= idx_d;
         gnt_q   <= gnt_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
         send_q  <= send_d;
         data_q  <= data_d;
      end
   end

   assign req_ack = ack_q;
   assign gnt     = gnt_q;
   assign busy    = busy_q;
   assign Send_en = send_q;
   assign data    = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized self-checking bench for uart_tx_arbiter with a frame-level reference model.
module tb_uart_tx_arbiter;

   localparam int N = 4;
   localparam logic [7:0] HDR = 8'hA0;

   logic             Clk;
   logic             Rst_n;
   logic [N-1:0]     req;
   logic [32*N-1:0]  req_data;
   logic [N-1:0]     req_ack;
   logic [N-1:0]     gnt;
   logic             busy;
   logic             TX_Done;
   logic             Send_en;
   logic [7:0]       data;

   uart_tx_arbiter #(.NUM_REQ(N), .HEADER(HDR)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .req(req), .req_data(req_data),
      .req_ack(req_ack), .gnt(gnt), .busy(busy),
      .TX_Done(TX_Done), .Send_en(Send_en), .data(data)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   // UART model state (written only by the responder process)
   logic [7:0] rx_q[$];
   bit         pending;
   int         cnt;
   int         spur_done;
   bit         double_send;
   int         done_cyc;

   // Stimulus knobs (written only by the test process)
   int  spur_req = 0;
   bit  rand_delay = 1'b1;
   int  fixed_delay = 10;
   int  rx_base = 0;
   int  m_ptr = 0;
   bit  gnt_bad = 1'b0;

   // UART TX model: records each byte at Send_en, answers with TX_Done after a delay
   initial begin
      TX_Done = 1'b0; pending = 1'b0; cnt = 0; spur_done = 0;
      double_send = 1'b0; done_cyc = -10;
      forever begin
         @(negedge Clk);
         TX_Done = 1'b0;
         if (!Rst_n) pending = 1'b0;
         else if (pending) begin
            if (cnt == 0) begin TX_Done = 1'b1; pending = 1'b0; done_cyc = cyc; end
            else cnt--;
         end else if (spur_done < spur_req) begin
            TX_Done = 1'b1; spur_done++;
         end
         if (Send_en) begin
            rx_q.push_back(data);
            if (pending) double_send = 1'b1;
            pending = 1'b1;
            cnt = (rand_delay ? int'($urandom_range(12, 1)) : fixed_delay) - 1;
         end
      end
   end

   // Serve one frame: model picks winner from m_ptr and current req, then all frame properties are checked
   task automatic serve_one(input bit hold, input bit corrupt, input string nm);
      int w;
      int c;
      logic [31:0] word;
      logic [7:0]  exp_q[$];
      logic [7:0]  h;
      logic [N-1:0] oh;
      logic [N-1:0] gs;
      bit got;
      w = -1;
      for (int k = 0; k < N; k++) begin
         c = (m_ptr + k) % N;
         if (w < 0 && req[c]) w = c;
      end
      checks++;
      if (w < 0) begin
         errors++;
         $display("FAIL %s model: no request pending, req=%b", nm, req);
         return;
      end
      word = req_data[32*w +: 32];
      h = HDR | 8'(w);
      exp_q = '{h, word[31:24], word[23:16], word[15:8], word[7:0]};
`ifdef UART_ARB_CHECKSUM_EN
      exp_q.push_back(h ^ word[31:24] ^ word[23:16] ^ word[15:8] ^ word[7:0]);
`endif
      oh = '0; oh[w] = 1'b1;
      gs = '0; got = 1'b0;
      for (int t = 0; t < 3000; t++) begin
         @(negedge Clk);
         if (busy && gs == '0) gs = gnt;
         if (busy && gnt !== gs) gnt_bad = 1'b1;
         if (corrupt && busy) req_data[32*w +: 32] = 32'h0;
         if (req_ack !== '0) begin got = 1'b1; break; end
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s timeout: no req_ack within 3000 cycles", nm);
         return;
      end
      checks++;
      if (req_ack !== oh) begin errors++; $display("FAIL %s req_ack: got %b want %b", nm, req_ack, oh); end
      checks++;
      if (gs !== oh) begin errors++; $display("FAIL %s gnt: got %b want %b", nm, gs, oh); end
      checks++;
      if (busy !== 1'b0 || gnt !== '0) begin
         errors++; $display("FAIL %s release: busy=%b gnt=%b want 0", nm, busy, gnt);
      end
      checks++;
      if (cyc !== done_cyc + 1) begin
         errors++; $display("FAIL %s ack_latency: ack cycle %0d want %0d", nm, cyc, done_cyc + 1);
      end
      checks++;
      if (rx_q.size() - rx_base != exp_q.size()) begin
         errors++; $display("FAIL %s length: got %0d bytes want %0d", nm, rx_q.size() - rx_base, exp_q.size());
      end else begin
         for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (rx_q[rx_base + k] !== exp_q[k]) begin
               errors++; $display("FAIL %s byte%0d: got %h want %h", nm, k, rx_q[rx_base + k], exp_q[k]);
            end
         end
      end
      if (!hold) req[w] = 1'b0;
      m_ptr = (w + 1) % N;
      rx_base = rx_q.size();
   endtask

   task automatic test_reset();
      Rst_n = 1'b0; req = '0; req_data = '0;
      repeat (3) @(negedge Clk);
      checks++;
      if ({req_ack, gnt, busy, Send_en, data} !== '0) begin
         errors++; $display("FAIL reset outputs: got ack=%b gnt=%b busy=%b send=%b data=%h want 0",
                             req_ack, gnt, busy, Send_en, data);
      end
      Rst_n = 1'b1;
      m_ptr = 0;
      repeat (2) @(negedge Clk);
      rx_base = rx_q.size();
   endtask

   task automatic test_single();
      rand_delay = 1'b0; fixed_delay = 10;
      req_data[31:0] = 32'h12345678;
      req = 4'b0001;
      @(negedge Clk);
      checks++;
      if (gnt !== '0 || busy !== 1'b0) begin errors++; $display("FAIL single N+1: gnt=%b busy=%b want 0", gnt, busy); end
      @(negedge Clk);
      checks++;
      if (gnt !== 4'b0001 || busy !== 1'b1) begin errors++; $display("FAIL single N+2: gnt=%b busy=%b want 0001/1", gnt, busy); end
      @(negedge Clk);
      checks++;
      if (Send_en !== 1'b1 || data !== 8'hA0) begin errors++; $display("FAIL single N+3: send=%b data=%h want 1/a0", Send_en, data); end
      serve_one(1'b0, 1'b0, "single");
      rand_delay = 1'b1;
   endtask

   task automatic test_round_robin();
      for (int i = 0; i < N; i++) req_data[32*i +: 32] = $urandom;
      req = 4'b1111;
      for (int i = 0; i < 5; i++) serve_one(1'b1, 1'b0, "round_robin");
      req = '0;
      repeat (3) @(negedge Clk);
   endtask

   task automatic test_wrap();
      req_data = {$urandom, $urandom, $urandom, $urandom};
      req = 4'b0100;
      serve_one(1'b0, 1'b0, "wrap_src2");
      req = 4'b0011;
      serve_one(1'b0, 1'b0, "wrap_to0");
      serve_one(1'b0, 1'b0, "wrap_rest");
   endtask

   task automatic test_stability();
      req_data[63:32] = 32'hDEADBEEF;
      req = 4'b0010;
      serve_one(1'b0, 1'b1, "stability");
   endtask

   task automatic test_spurious();
      repeat (3) @(negedge Clk);
      spur_req = spur_req + 3;
      repeat (12) @(negedge Clk);
      checks++;
      if (rx_q.size() != rx_base || busy !== 1'b0) begin
         errors++; $display("FAIL spurious idle: bytes=%0d busy=%b want 0/0", rx_q.size() - rx_base, busy);
      end
      rand_delay = 1'b0; fixed_delay = 1;
      req_data[127:96] = $urandom;
      req = 4'b1000;
      serve_one(1'b0, 1'b0, "fast_done");
      rand_delay = 1'b1;
   endtask

   task automatic test_random();
      for (int r = 0; r < 8; r++) begin
         req_data = {$urandom, $urandom, $urandom, $urandom};
         req = 4'($urandom_range(15, 1));
         while (req != '0) serve_one(1'b0, 1'b0, "random");
      end
   endtask

   task automatic test_reset_mid_frame();
      bit reached;
      req_data = {$urandom, $urandom, $urandom, $urandom};
      req = 4'b0010;
      serve_one(1'b0, 1'b0, "pre_reset");
      req = 4'b1000;
      reached = 1'b0;
      for (int t = 0; t < 1000; t++) begin
         @(negedge Clk);
         if (rx_q.size() >= rx_base + 3) begin reached = 1'b1; break; end
      end
      checks++;
      if (!reached) begin errors++; $display("FAIL reset_mid timeout: bytes=%0d want 3", rx_q.size() - rx_base); end
      @(negedge Clk);
      Rst_n = 1'b0;
      @(negedge Clk);
      checks++;
      if ({req_ack, gnt, busy, Send_en, data} !== '0) begin
         errors++; $display("FAIL reset_mid outputs: ack=%b gnt=%b busy=%b send=%b data=%h want 0",
                             req_ack, gnt, busy, Send_en, data);
      end
      repeat (2) begin
         @(negedge Clk);
         checks++;
         if (req_ack !== '0) begin errors++; $display("FAIL reset_mid ack: got %b want 0", req_ack); end
      end
      req = 4'b0110;
      Rst_n = 1'b1;
      m_ptr = 0;
      rx_base = rx_q.size();
      serve_one(1'b0, 1'b0, "after_reset_ptr0");
      serve_one(1'b0, 1'b0, "after_reset_src2");
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_wrap();
      test_stability();
      test_spurious();
      test_random();
      test_reset_mid_frame();
      checks++;
      if (double_send !== 1'b0) begin errors++; $display("FAIL double_send: got %b want 0", double_send); end
      checks++;
      if (gnt_bad !== 1'b0) begin errors++; $display("FAIL gnt_stable: got %b want 0", gnt_bad); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
